// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: control, handshake and strobe bundle between the sequencer and the datapath/memories
interface multicycle_sequencer_if #(parameter int COUNT_WIDTH = 32);
  logic start, stop, branch_taken, im_ready, dm_ready;
  logic [6:0] op_code;
  logic im_read_en, ir_load_en, dm_read_en, dm_write_en, rf_write_en, pc_write_en, pc_src;
  logic [1:0] wb_sel;
  logic busy, halted, illegal_op;
  logic [COUNT_WIDTH-1:0] instr_count;
  modport master (
    input  start, stop, op_code, branch_taken, im_ready, dm_ready,
    output im_read_en, ir_load_en, dm_read_en, dm_write_en, rf_write_en, pc_write_en, pc_src,
    output wb_sel, busy, halted, illegal_op, instr_count
  );
  modport slave (
    output start, stop, op_code, branch_taken, im_ready, dm_ready,
    input  im_read_en, ir_load_en, dm_read_en, dm_write_en, rf_write_en, pc_write_en, pc_src,
    input  wb_sel, busy, halted, illegal_op, instr_count
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: RV64 multicycle control FSM sequencing fetch/decode/execute/memory/writeback and counting retirements
module multicycle_sequencer #(parameter int COUNT_WIDTH = 32) (
  input logic clk,
  input logic rst_n,
  multicycle_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT} state_t;
  state_t state, state_next, after;
  logic is_alu, is_load, is_store, is_branch, is_jump, is_sys, legal, pc_write, illegal;
  logic [COUNT_WIDTH-1:0] count;
  assign is_alu    = bus.op_code inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111};
  assign is_load   = bus.op_code == 7'b0000011;
  assign is_store  = bus.op_code == 7'b0100011;
  assign is_branch = bus.op_code == 7'b1100011;
  assign is_jump   = bus.op_code inside {7'b1101111, 7'b1100111};
  assign is_sys    = bus.op_code == 7'b1110011;
  assign legal     = is_alu | is_load | is_store | is_branch | is_jump | is_sys;
  // every retirement is an instruction boundary; stop is honoured only here
  assign after     = bus.stop ? IDLE : FETCH;
  always_comb begin
    state_next      = state;
    bus.im_read_en  = 1'b0;
    bus.ir_load_en  = 1'b0;
    bus.dm_read_en  = 1'b0;
    bus.dm_write_en = 1'b0;
    bus.rf_write_en = 1'b0;
    pc_write        = 1'b0;
    bus.pc_src      = 1'b0;
    bus.wb_sel      = 2'b00;
    case (state)
      IDLE: state_next = (bus.start && !bus.stop) ? FETCH : IDLE;
      FETCH: begin
        bus.im_read_en = 1'b1;
        bus.ir_load_en = bus.im_ready;
        state_next     = bus.im_ready ? DECODE : FETCH;
      end
      DECODE: state_next = (is_sys || !legal) ? HALT : EXECUTE;
      EXECUTE: begin
        pc_write   = is_branch;
        bus.pc_src = is_branch && bus.branch_taken;
        state_next = is_branch ? after : (is_load || is_store) ? MEMORY : WRITEBACK;
      end
      MEMORY: begin
        bus.dm_read_en  = is_load;
        bus.dm_write_en = is_store;
        pc_write        = is_store && bus.dm_ready;
        state_next      = !bus.dm_ready ? MEMORY : is_store ? after : WRITEBACK;
      end
      WRITEBACK: begin
        bus.rf_write_en = 1'b1;
        pc_write        = 1'b1;
        bus.pc_src      = is_jump;
        bus.wb_sel      = is_jump ? 2'b10 : is_load ? 2'b01 : 2'b00;
        state_next      = after;
      end
      default: state_next = state;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      illegal <= 1'b0;
      count   <= '0;
    end else begin
      state <= state_next;
      if (state == DECODE && !legal) illegal <= 1'b1;
      if (pc_write) count <= count + 1'b1;
    end
  assign bus.pc_write_en = pc_write;
  assign bus.busy        = state != IDLE && state != HALT;
  assign bus.halted      = state == HALT;
  assign bus.illegal_op  = illegal;
  assign bus.instr_count = count;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed and randomized checks of the sequencer against a phase-sum reference model
module tb_multicycle_sequencer;
  localparam int CW = 4;
  typedef enum int {C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_SYS, C_ILL} cls_t;
  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;
  multicycle_sequencer_if #(.COUNT_WIDTH(CW)) bus();
  multicycle_sequencer #(.COUNT_WIDTH(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0, errors = 0, cnt_model = 0;
  int m_lat, m_im, m_ir, m_dmr, m_dmw, m_rf, m_pcw, m_pcsrc, m_wb, m_cnt;
  bit m_halt, m_to, m_busy;
  logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                                7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111};

  function automatic cls_t classify(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: return C_ALU;
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b1100011: return C_BRANCH;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b1110011: return C_SYS;
      default:    return C_ILL;
    endcase
  endfunction

  // cycles from FETCH entry to retire = sum of the phases the instruction passes through
  function automatic int exp_lat(input cls_t c, input int wi, input int wd);
    bit mem = c == C_LOAD || c == C_STORE;
    bit wr  = c == C_ALU || c == C_LOAD || c == C_JAL || c == C_JALR;
    return (wi + 1) + 1 + 1 + (mem ? wd + 1 : 0) + (wr ? 1 : 0);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    {bus.start, bus.stop, bus.branch_taken, bus.im_ready, bus.dm_ready} = '0;
    bus.op_code = 7'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt_model = 0;
  endtask

  task automatic run_instr(input logic [6:0] op, input int wi, input int wd, input bit bt, input int stop_at);
    int n = 0;
    {m_lat, m_im, m_ir, m_dmr, m_dmw, m_rf, m_pcw, m_pcsrc, m_wb} = '0;
    m_halt = 1'b0;
    m_to = 1'b1;
    bus.op_code = op;
    bus.branch_taken = bt;
    bus.start = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      bus.im_ready = (m_im == wi);
      bus.dm_ready = ((m_dmr + m_dmw) == wd);
      bus.stop = stop_at != 0 && n + 1 >= stop_at;
      #1;
      if (bus.halted) begin m_halt = 1'b1; m_to = 1'b0; m_lat = n; break; end
      if (bus.busy) n++;
      m_im += int'(bus.im_read_en);
      m_ir += int'(bus.ir_load_en);
      m_dmr += int'(bus.dm_read_en);
      m_dmw += int'(bus.dm_write_en);
      m_rf += int'(bus.rf_write_en);
      if (bus.pc_write_en) begin
        m_pcw++;
        m_lat = n;
        m_pcsrc = int'(bus.pc_src);
        m_wb = int'(bus.wb_sel);
        m_to = 1'b0;
        cnt_model = (cnt_model + 1) % (1 << CW);
        break;
      end
    end
    @(posedge clk);
    #1;
    m_busy = bus.busy;
    m_cnt = int'(bus.instr_count);
    checks++; if (m_to) begin errors++; $display("FAIL run_timeout op=%b got no retire/halt exp retire or halt", op); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.im_read_en, bus.ir_load_en, bus.dm_read_en, bus.dm_write_en, bus.rf_write_en, bus.pc_write_en, bus.pc_src, bus.wb_sel, bus.busy, bus.halted, bus.illegal_op} !== 12'b0)
      begin errors++; $display("FAIL reset_outputs got %b exp 0", {bus.im_read_en, bus.ir_load_en, bus.dm_read_en, bus.dm_write_en, bus.rf_write_en, bus.pc_write_en, bus.pc_src, bus.wb_sel, bus.busy, bus.halted, bus.illegal_op}); end
    checks++; if (bus.instr_count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.instr_count); end
    do_reset();
  endtask

  task automatic test_alu();
    run_instr(7'b0110011, 0, 0, 1'b0, 0);
    checks++; if (m_lat !== 4) begin errors++; $display("FAIL alu_latency got %0d exp 4", m_lat); end
    checks++; if (m_rf !== 1 || m_wb !== 0 || m_pcsrc !== 0) begin errors++; $display("FAIL alu_wb got rf=%0d wb=%0d src=%0d exp 1 0 0", m_rf, m_wb, m_pcsrc); end
    checks++; if (m_cnt !== 1) begin errors++; $display("FAIL alu_count got %0d exp 1", m_cnt); end
  endtask

  task automatic test_load_wait();
    run_instr(7'b0000011, 0, 3, 1'b0, 0);
    checks++; if (m_dmr !== 4 || m_dmw !== 0) begin errors++; $display("FAIL load_dm_read got rd=%0d wr=%0d exp 4 0", m_dmr, m_dmw); end
    checks++; if (m_wb !== 1) begin errors++; $display("FAIL load_wb_sel got %0d exp 1", m_wb); end
    checks++; if (m_lat !== 8) begin errors++; $display("FAIL load_latency got %0d exp 8", m_lat); end
  endtask

  task automatic test_branch();
    for (int t = 1; t >= 0; t--) begin
      run_instr(7'b1100011, 1, 0, t[0], 0);
      checks++; if (m_lat !== 4 || m_pcsrc !== t) begin errors++; $display("FAIL branch_%0d got lat=%0d src=%0d exp 4 %0d", t, m_lat, m_pcsrc, t); end
      checks++; if (m_rf !== 0 || m_busy !== 1'b1) begin errors++; $display("FAIL branch_rf_%0d got rf=%0d busy=%0d exp 0 1", t, m_rf, m_busy); end
    end
  endtask

  task automatic test_store_stop();
    run_instr(7'b0100011, 0, 1, 1'b0, 3);
    checks++; if (m_dmw !== 2 || m_lat !== 5) begin errors++; $display("FAIL store_stop got dmw=%0d lat=%0d exp 2 5", m_dmw, m_lat); end
    checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL store_stop_idle got busy=%0d exp 0", m_busy); end
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stop_priority got busy=%0d exp 0", bus.busy); end
    bus.stop = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b1 || bus.im_read_en !== 1'b1) begin errors++; $display("FAIL restart got busy=%0d im=%0d exp 1 1", bus.busy, bus.im_read_en); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      logic [6:0] op = legal_ops[$urandom_range(0, 8)];
      int wi = $urandom_range(0, 3), wd = $urandom_range(0, 3);
      bit bt = 1'($urandom);
      cls_t c = classify(op);
      int e_src = (c == C_BRANCH) ? int'(bt) : (c == C_JAL || c == C_JALR) ? 1 : 0;
      int e_wb = (c == C_JAL || c == C_JALR) ? 2 : (c == C_LOAD) ? 1 : 0;
      int e_rf = (c == C_ALU || c == C_LOAD || c == C_JAL || c == C_JALR) ? 1 : 0;
      int e_dmr = (c == C_LOAD) ? wd + 1 : 0, e_dmw = (c == C_STORE) ? wd + 1 : 0;
      run_instr(op, wi, wd, bt, 0);
      checks++; if (m_lat !== exp_lat(c, wi, wd)) begin errors++; $display("FAIL rnd%0d_latency op=%b got %0d exp %0d", k, op, m_lat, exp_lat(c, wi, wd)); end
      checks++; if (m_im !== wi + 1 || m_ir !== 1) begin errors++; $display("FAIL rnd%0d_fetch got im=%0d ir=%0d exp %0d 1", k, m_im, m_ir, wi + 1); end
      checks++; if (m_dmr !== e_dmr || m_dmw !== e_dmw) begin errors++; $display("FAIL rnd%0d_dm got rd=%0d wr=%0d exp %0d %0d", k, m_dmr, m_dmw, e_dmr, e_dmw); end
      checks++; if (m_rf !== e_rf || m_pcw !== 1) begin errors++; $display("FAIL rnd%0d_rf got rf=%0d pcw=%0d exp %0d 1", k, m_rf, m_pcw, e_rf); end
      checks++; if (m_pcsrc !== e_src || m_wb !== e_wb) begin errors++; $display("FAIL rnd%0d_sel got src=%0d wb=%0d exp %0d %0d", k, m_pcsrc, m_wb, e_src, e_wb); end
      checks++; if (m_cnt !== cnt_model || m_busy !== 1'b1) begin errors++; $display("FAIL rnd%0d_count got cnt=%0d busy=%0d exp %0d 1", k, m_cnt, m_busy, cnt_model); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      run_instr(7'b0010011, 0, 0, 1'b0, 0);
      if (k == 14) begin checks++; if (m_cnt !== 15) begin errors++; $display("FAIL wrap_max got %0d exp 15", m_cnt); end end
    end
    checks++; if (m_cnt !== 0) begin errors++; $display("FAIL wrap_zero got %0d exp 0", m_cnt); end
  endtask

  task automatic test_illegal();
    do_reset();
    run_instr(7'b0000000, 0, 0, 1'b0, 0);
    checks++; if (!m_halt || m_lat !== 2 || m_pcw !== 0) begin errors++; $display("FAIL illegal_halt got halt=%0d lat=%0d pcw=%0d exp 1 2 0", m_halt, m_lat, m_pcw); end
    checks++; if (bus.illegal_op !== 1'b1 || bus.instr_count !== '0) begin errors++; $display("FAIL illegal_flag got ill=%0d cnt=%0d exp 1 0", bus.illegal_op, bus.instr_count); end
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.halted !== 1'b1 || bus.busy !== 1'b0 || bus.im_read_en !== 1'b0) begin errors++; $display("FAIL halt_absorb got halted=%0d busy=%0d im=%0d exp 1 0 0", bus.halted, bus.busy, bus.im_read_en); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.halted !== 1'b0 || bus.illegal_op !== 1'b0) begin errors++; $display("FAIL halt_reset got halted=%0d ill=%0d exp 0 0", bus.halted, bus.illegal_op); end
    do_reset();
    run_instr(7'b1110011, 2, 0, 1'b0, 0);
    checks++; if (!m_halt || m_lat !== 4 || bus.illegal_op !== 1'b0) begin errors++; $display("FAIL system_halt got halt=%0d lat=%0d ill=%0d exp 1 4 0", m_halt, m_lat, bus.illegal_op); end
  endtask

  task automatic test_mid_reset();
    bit seen = 1'b0;
    do_reset();
    run_instr(7'b0110111, 0, 0, 1'b0, 0);
    bus.op_code = 7'b0000011;
    bus.im_ready = 1'b1;
    bus.dm_ready = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      #1;
      seen = bus.dm_read_en;
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_reset_reach got no dm_read_en exp dm_read_en"); end
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.im_read_en, bus.ir_load_en, bus.dm_read_en, bus.dm_write_en, bus.rf_write_en, bus.pc_write_en, bus.pc_src, bus.wb_sel, bus.busy, bus.halted, bus.illegal_op} !== 12'b0 || bus.instr_count !== '0)
      begin errors++; $display("FAIL mid_reset got dmr=%0d busy=%0d cnt=%0d exp 0 0 0", bus.dm_read_en, bus.busy, bus.instr_count); end
    do_reset();
  endtask

  initial begin
    {bus.start, bus.stop, bus.branch_taken, bus.im_ready, bus.dm_ready} = '0;
    bus.op_code = 7'b0;
    #2;
    test_reset();
    test_alu();
    test_load_wait();
    test_branch();
    test_random();
    test_store_stop();
    test_wrap();
    test_illegal();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multicycle control FSM for the RV64 datapath. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the strobes for the PC, IR, register file and data memory. Per-instruction field decode and ALU operation select are done elsewhere. It sits between the instruction and data memory handshakes and the combinational decoder. It also counts retired instructions.

## Interface
- COUNT_WIDTH, 32, width of the retired-instruction counter
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  leave IDLE and begin fetching (level, sampled in IDLE)
- stop  in  1  return to IDLE at the next instruction boundary (level)
- op_code  in  7  opcode field of the IR (valid from DECODE onward)
- branch_taken  in  1  branch condition result from the ALU (valid in EXECUTE)
- im_ready  in  1  instruction memory has returned the word
- dm_ready  in  1  data memory access complete
- im_read_en  out  1  instruction fetch request
- ir_load_en  out  1  load the IR
- dm_read_en  out  1  data memory read request
- dm_write_en  out  1  data memory write request
- rf_write_en  out  1  register file write strobe
- pc_write_en  out  1  PC update strobe; marks retirement
- pc_src  out  1  0 = PC+4, 1 = target (branch or jump)
- wb_sel  out  2  00 = ALU, 01 = memory data, 10 = PC+4
- busy  out  1  state is not IDLE and not HALT
- halted  out  1  state is HALT
- illegal_op  out  1  sticky; set when HALT was entered on an unknown opcode
- instr_count  out  COUNT_WIDTH  retired instructions, wraps modulo 2^COUNT_WIDTH

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT. The state register is 3 bits.
- Opcode classes:
  - R 0110011, I 0010011, LUI 0110111, AUIPC 0010111 are ALU ops.
  - 0000011 is LOAD; 0100011 is STORE; 1100011 is BRANCH.
  - 1101111 is JAL; 1100111 is JALR; 1110011 is SYSTEM.
  - Any other opcode is illegal.
- IDLE:
  - start=1 goes to FETCH; otherwise stay.
  - While stop=1, IDLE ignores start (stop has priority).
- FETCH:
  - im_read_en=1.
  - While im_ready=0, stay.
  - When im_ready=1, ir_load_en=1 in that same cycle, then go to DECODE.
- DECODE: one cycle.
  - SYSTEM goes to HALT.
  - An illegal opcode goes to HALT and sets illegal_op.
  - Otherwise go to EXECUTE.
- EXECUTE: one cycle.
  - BRANCH: pc_write_en=1, pc_src=branch_taken, then go to boundary.
  - LOAD or STORE: go to MEMORY.
  - All others: go to WRITEBACK.
- MEMORY:
  - LOAD holds dm_read_en=1; STORE holds dm_write_en=1, each until dm_ready=1.
  - STORE on dm_ready: pc_write_en=1, pc_src=0, then go to boundary.
  - LOAD on dm_ready: go to WRITEBACK.
- WRITEBACK: one cycle.
  - rf_write_en=1 and pc_write_en=1.
  - JAL/JALR: pc_src=1, wb_sel=10.
  - LOAD: pc_src=0, wb_sel=01.
  - Others: pc_src=0, wb_sel=00.
  - Then go to boundary.
- Boundary (the cycle where pc_write_en=1): next state is IDLE if stop=1, else FETCH.
- HALT: absorbing. Only reset leaves it. All strobes are 0.
- instr_count increments by 1 on every cycle with pc_write_en=1. SYSTEM and illegal instructions do not retire.
- In any state not listed for a strobe, that strobe is 0. pc_src and wb_sel are 0 outside the states that set them.

## Timing
- All outputs are combinational from the registered state, op_code and the ready/branch inputs (Mealy on im_ready and dm_ready). The state register, illegal_op and instr_count are registered.
- Reset (asynchronous, rst_n=0): state=IDLE, illegal_op=0, instr_count=0, all strobes 0, busy=0, halted=0. The same applies when reset is asserted mid-instruction: in-flight requests drop the same cycle.
- Minimum cycle counts with zero-wait memory, from FETCH entry to retire:
  - ALU, JAL, JALR: 4 cycles.
  - BRANCH: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each wait cycle on im_ready or dm_ready adds 1 cycle. Request strobes stay constant while waiting.
- A stop asserted mid-instruction does not abort; it takes effect only at the boundary.
- At the boundary, start is not sampled.
- instr_count rolls from 2^COUNT_WIDTH-1 to 0 without a flag.

## Test plan
- ALU op 0110011, start=1, im_ready=1 and dm_ready=1 constantly -> states FETCH, DECODE, EXECUTE, WRITEBACK. rf_write_en and pc_write_en are high in cycle 4; instr_count=1.
- LOAD with dm_ready held low 3 cycles -> dm_read_en high for 4 cycles; wb_sel=01 in WRITEBACK; retire at cycle 8.
- BRANCH with branch_taken=1, then again with branch_taken=0 -> pc_write_en in EXECUTE with pc_src=1, then pc_src=0; rf_write_en never high.
- op_code 0000000 -> HALT after DECODE; illegal_op=1, halted=1, no retire. Pulsing start leaves the state unchanged. rst_n low clears everything.
- stop raised in EXECUTE of a STORE -> the store completes and dm_write_en is seen; then IDLE with busy=0.
- COUNT_WIDTH=4, 16 retires -> instr_count wraps to 0. rst_n low while in MEMORY -> IDLE immediately, all outputs 0.
